spi_adc_slave: RTL and testbench
================================

Name: spi_adc_slave

Overview:
- SPI responder that emulates a serial 8-bit ADC (ADC081S021-style frame) at the far end of our SPI master's cs_n/sclk/sdata link.
- Oversamples cs_n and sclk in the system clock domain, latches a sample at frame start, and shifts a framed word out MSB-first on sdata.
- Used for board-level loopback and simulation of the ADC capture → UART/FND path without a physical converter.

Parameters:
- DATA_W, 8, sample width in bits.
- LEAD_ZEROS, 3, zero bits sent before the sample MSB.
- FRAME_BITS, 16, total sclk cycles per frame; must be ≥ LEAD_ZEROS+DATA_W; remaining bits are trailing zeros.
- CNT_W, 5, width of bit counters; must satisfy 2^CNT_W > FRAME_BITS.

Ports:
- clk  input  1  system clock; must be ≥8× sclk frequency.
- n_rst  input  1  asynchronous active-low reset.
- cs_n  input  1  chip select from master, active low, asynchronous to clk.
- sclk  input  1  serial clock from master, idle high, asynchronous to clk.
- sample  input  DATA_W  external sample value, used when pattern_en=0.
- pattern_en  input  1  1 = send internal ramp counter instead of sample.
- sdata  output  1  serial data to master.
- sdata_oe  output  1  high while this block owns sdata (frame active).
- busy  output  1  high from frame start until cs_n returns high.
- frame_done  output  1  one-clk pulse on a completed frame.
- frame_abort  output  1  one-clk pulse when cs_n rises mid-frame.

Behaviour:
- Reset (async, n_rst=0): sdata=0, sdata_oe=0, busy=0, frame_done=0, frame_abort=0, ramp counter=0, state=IDLE, sync flops cs_n=1 and sclk=1.
- Synchronisation: cs_n and sclk each pass a 2-flop synchroniser, then a third register for edge detection. Edge events are single-clk pulses.
- Frame word: {LEAD_ZEROS zeros, latched sample, FRAME_BITS-LEAD_ZEROS-DATA_W zeros}, sent MSB first.
- States:
  - IDLE: outputs low.
    - On synced cs_n falling edge: latch sample, or the ramp counter if pattern_en=1. Load the shift register with the frame word, tx index=0, rise count=0.
    - Assert sdata_oe and busy, drive sdata=frame[FRAME_BITS-1], go to SHIFT.
    - Latency: 3 clk from cs_n pin low to sdata_oe high.
  - SHIFT:
    - Each synced sclk falling edge: shift left by one and drive the next bit. Latency is 3 clk from pin edge to sdata update. The first falling edge after cs_n falls therefore presents bit FRAME_BITS-2. Once the index passes the last bit, drive 0.
    - Each synced sclk rising edge: rise count +1.
    - When rise count reaches FRAME_BITS: pulse frame_done, increment the ramp counter (DATA_W-bit wrap, 0xFF→0x00), go to DONE.
  - DONE:
    - sdata=0; sclk edges ignored; sdata_oe and busy stay high.
    - On synced cs_n rising edge: sdata_oe=0, busy=0, go to IDLE.
- Abort: synced cs_n rising edge while in SHIFT → pulse frame_abort, no frame_done, ramp not incremented, outputs to reset values, go to IDLE.
- Simultaneous events:
  - cs_n rise and the final sclk rise in the same clk: abort wins.
  - sclk edges while cs_n high are ignored in all states.
- sample and pattern_en are sampled only at frame start; changes mid-frame have no effect.
- A new cs_n fall is accepted only in IDLE; the earliest is 1 clk after returning to IDLE.

Test Plan:
- Reset mid-SHIFT (n_rst low 2 clk after 5 sclk falls) → all outputs 0 immediately; next frame with sample=8'h3C transmits 0x0780 correctly.
- pattern_en=0, sample=8'hA5, master runs 16 sclk cycles at clk/10 → master receives 0x14A0; frame_done pulses once; sdata_oe high from cs_n+3 clk until cs_n rise+3 clk.
- pattern_en=1 after reset, 3 back-to-back full frames → extracted samples 0x00, 0x01, 0x02. Preset the ramp to 0xFF via 255 frames → next 0xFF, then 0x00.
- cs_n raised after 7 sclk cycles with sample=8'hFF → frame_abort pulses once, no frame_done, ramp unchanged, next frame starts cleanly from bit 15.
- sample changed 8'h55→8'hAA after frame start → the frame still carries 0x55; the following frame carries 0xAA.
- sclk toggling 4 cycles with cs_n high, then 20 sclk cycles in one frame → no output activity while cs_n high; frame_done after the 16th rise; sdata=0 for the extra 4 bits; busy held until cs_n rises.

Source files
------------

// File: rtl/spi_adc_slave.sv
// spi_adc_slave
//   Emulates a serial 8-bit ADC at the far end of an SPI link. cs_n and sclk
//   are oversampled in the clk domain. On a cs_n fall a sample is latched and
//   a framed word is shifted out MSB first on sdata, one bit per sclk fall.
//
// Ports
//   clk         system clock, at least 8x the sclk frequency
//   n_rst       asynchronous active-low reset
//   cs_n        chip select from the master, active low, asynchronous to clk
//   sclk        serial clock from the master, idle high, asynchronous to clk
//   sample      external sample value, sent when pattern_en=0
//   pattern_en  1 = send the internal ramp counter instead of sample
//   sdata       serial data to the master
//   sdata_oe    high while this block owns sdata (frame active)
//   busy        high from frame start until cs_n returns high
//   frame_done  one-clk pulse on a completed frame
//   frame_abort one-clk pulse when cs_n rises mid-frame
module spi_adc_slave #(
   parameter int DATA_W     = 8,
   parameter int LEAD_ZEROS = 3,
   parameter int FRAME_BITS = 16,
   parameter int CNT_W      = 5
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              cs_n,
   input  logic              sclk,
   input  logic [DATA_W-1:0] sample,
   input  logic              pattern_en,
   output logic              sdata,
   output logic              sdata_oe,
   output logic              busy,
   output logic              frame_done,
   output logic              frame_abort
);

   localparam int TRAIL = FRAME_BITS - LEAD_ZEROS - DATA_W;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_BITS - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   // [0],[1] are the synchroniser, [2] is the edge-detect delay stage.
   logic [2:0] cs_sr, sclk_sr;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cs_sr   <= 3'b111;
         sclk_sr <= 3'b111;
      end else begin
         cs_sr   <= {cs_sr[1:0], cs_n};
         sclk_sr <= {sclk_sr[1:0], sclk};
      end
   end

   logic cs_fall, cs_rise, sclk_fall, sclk_rise;
   assign cs_fall   =  cs_sr[2] & ~cs_sr[1];
   assign cs_rise   = ~cs_sr[2] &  cs_sr[1];
   // sclk activity only counts while the synced chip select is asserted.
   assign sclk_fall =  sclk_sr[2] & ~sclk_sr[1] & ~cs_sr[1];
   assign sclk_rise = ~sclk_sr[2] &  sclk_sr[1] & ~cs_sr[1];

   state_t                state_q, state_d;
   logic [FRAME_BITS-1:0] shreg_q, shreg_d;
   logic [CNT_W-1:0]      tx_q, tx_d;
   logic [CNT_W-1:0]      rise_q, rise_d;
   logic [DATA_W-1:0]     ramp_q, ramp_d;
   logic                  sdata_q, sdata_d;
   logic                  oe_q, oe_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  abort_q, abort_d;

   logic [DATA_W-1:0]     smp;
   logic [FRAME_BITS-1:0] word_init;

   // Frame word: leading zeros, sample, trailing zeros.
   assign smp       = pattern_en ? ramp_q : sample;
   assign word_init = FRAME_BITS'(smp) << TRAIL;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         shreg_q <= '0;
         tx_q    <= '0;
         rise_q  <= '0;
         ramp_q  <= '0;
         sdata_q <= 1'b0;
         oe_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         abort_q <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         tx_q    <= tx_d;
         rise_q  <= rise_d;
         ramp_q  <= ramp_d;
         sdata_q <= sdata_d;
         oe_q    <= oe_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         abort_q <= abort_d;
      end
   end

   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      tx_d    = tx_q;
      rise_d  = rise_q;
      ramp_d  = ramp_q;
      sdata_d = sdata_q;
      oe_d    = oe_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      abort_d = 1'b0;
      case (state_q)
         IDLE: begin
            sdata_d = 1'b0;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            if (cs_fall) begin
               shreg_d = word_init;
               tx_d    = '0;
               rise_d  = '0;
               sdata_d = word_init[FRAME_BITS-1];
               oe_d    = 1'b1;
               busy_d  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            // A cs_n rise masks sclk edges, so abort always wins over a
            // coincident final rise.
            if (cs_rise) begin
               abort_d = 1'b1;
               sdata_d = 1'b0;
               oe_d    = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               if (sclk_fall) begin
                  shreg_d = shreg_q << 1;
                  if (tx_q < LAST) begin
                     tx_d    = tx_q + CNT_W'(1);
                     sdata_d = shreg_q[FRAME_BITS-2];
                  end else begin
                     sdata_d = 1'b0;
                  end
               end
               if (sclk_rise) begin
                  if (rise_q == LAST) begin
                     done_d  = 1'b1;
                     ramp_d  = ramp_q + DATA_W'(1);
                     sdata_d = 1'b0;
                     state_d = DONE;
                  end else begin
                     rise_d = rise_q + CNT_W'(1);
                  end
               end
            end
         end
         DONE: begin
            sdata_d = 1'b0;
            if (cs_rise) begin
               oe_d    = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign sdata       = sdata_q;
   assign sdata_oe    = oe_q;
   assign busy        = busy_q;
   assign frame_done  = done_q;
   assign frame_abort = abort_q;

endmodule

// File: tb/tb_spi_adc_slave.sv
// Self-checking bench for spi_adc_slave: a behavioural SPI master drives
// frames, a reference model pushes the expected result of each frame into a
// queue, and a monitor pops and compares on every frame_done/frame_abort.
module tb_spi_adc_slave;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       cs_n = 1'b1;
   logic       sclk = 1'b1;
   logic [7:0] sample = 8'h00;
   logic       pattern_en = 1'b0;
   logic       sdata, sdata_oe, busy, frame_done, frame_abort;

   always #5 clk = ~clk;

   spi_adc_slave dut (
      .clk(clk), .n_rst(n_rst), .cs_n(cs_n), .sclk(sclk),
      .sample(sample), .pattern_en(pattern_en),
      .sdata(sdata), .sdata_oe(sdata_oe), .busy(busy),
      .frame_done(frame_done), .frame_abort(frame_abort)
   );

   typedef struct {
      bit          is_abort;
      logic [15:0] word;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad = 0;
   int unsigned ramp_m = 0;
   logic [15:0] cap = '0;
   int          ncap = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One SPI frame of ncyc sclk cycles. Master samples sdata at each sclk
   // fall (captured by the monitor). The expectation is pushed up front.
   task automatic frame(input int ncyc, input int half, input bit chg, input logic [7:0] chg_val);
      logic [7:0] smp;
      exp_t       e;
      smp        = pattern_en ? 8'(ramp_m) : sample;
      e.is_abort = (ncyc < 16);
      e.word     = 16'(smp) << 5;
      q.push_back(e);
      if (!e.is_abort) ramp_m = (ramp_m + 1) % 256;
      cs_n = 1'b0;
      tick(2);
      chk("oe_before_lat", sdata_oe, 1'b0);
      tick(1);
      chk("oe_at_lat", sdata_oe, 1'b1);
      chk("busy_at_lat", busy, 1'b1);
      tick(1);
      for (int i = 0; i < ncyc; i++) begin
         sclk = 1'b0;
         tick(half);
         if (chg && i == 2) sample = chg_val;
         if (i >= 16) chk("extra_bit_zero", sdata, 1'b0);
         sclk = 1'b1;
         tick(half);
      end
      chk("busy_hold", busy, 1'b1);
      chk("oe_hold", sdata_oe, 1'b1);
      cs_n = 1'b1;
      tick(2);
      chk("oe_before_release", sdata_oe, 1'b1);
      tick(1);
      chk("oe_release", sdata_oe, 1'b0);
      chk("busy_release", busy, 1'b0);
      chk("sdata_idle", sdata, 1'b0);
      tick(1);
   endtask

   task automatic do_reset();
      n_rst = 1'b0;
      tick(2);
      n_rst = 1'b1;
      ramp_m = 0;
      tick(3);
   endtask

   // Capture: first 16 sdata values seen at sclk falls while cs_n is low.
   initial begin
      forever begin
         @(negedge cs_n);
         cap  = '0;
         ncap = 0;
         while (cs_n === 1'b0) begin
            @(negedge sclk or posedge cs_n);
            if (cs_n === 1'b0 && ncap < 16) begin
               cap = {cap[14:0], sdata};
               ncap++;
            end
         end
      end
   end

   // Scoreboard monitor.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (frame_done === 1'b1 || frame_abort === 1'b1) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_pulse done=%0b abort=%0b t=%0t", frame_done, frame_abort, $time);
            end else begin
               e = q.pop_front();
               chk("pulse_done", frame_done, !e.is_abort);
               chk("pulse_abort", frame_abort, e.is_abort);
               if (!e.is_abort) begin
                  chk("frame_word", cap, e.word);
                  chk("frame_nbits", ncap, 16);
               end
            end
         end
      end
   end

   initial begin
      #5000000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      tick(3);
      chk("rst_sdata", sdata, 1'b0);
      chk("rst_oe", sdata_oe, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", frame_done, 1'b0);
      chk("rst_abort", frame_abort, 1'b0);
      n_rst = 1'b1;
      tick(3);

      // Reset mid-SHIFT: 5 sclk falls, then reset 2 clk later.
      sample = 8'h99;
      cs_n = 1'b0;
      tick(4);
      for (int i = 0; i < 5; i++) begin
         sclk = 1'b0;
         tick(5);
         if (i < 4) begin
            sclk = 1'b1;
            tick(5);
         end
      end
      chk("pre_rst_oe", sdata_oe, 1'b1);
      tick(2);
      n_rst = 1'b0;
      #1;
      chk("midrst_sdata", sdata, 1'b0);
      chk("midrst_oe", sdata_oe, 1'b0);
      chk("midrst_busy", busy, 1'b0);
      chk("midrst_done", frame_done, 1'b0);
      chk("midrst_abort", frame_abort, 1'b0);
      tick(2);
      cs_n = 1'b1;
      sclk = 1'b1;
      tick(2);
      n_rst = 1'b1;
      ramp_m = 0;
      tick(5);
      sample = 8'h3C;
      frame(16, 5, 1'b0, 8'h00);

      // Plain sample at clk/10.
      sample = 8'hA5;
      frame(16, 5, 1'b0, 8'h00);

      // Ramp pattern from reset, then wrap 0xFF -> 0x00.
      do_reset();
      pattern_en = 1'b1;
      for (int i = 0; i < 3; i++) frame(16, 5, 1'b0, 8'h00);
      while (ramp_m != 255) frame(16, 4, 1'b0, 8'h00);
      frame(16, 5, 1'b0, 8'h00);
      frame(16, 5, 1'b0, 8'h00);

      // Abort after 7 sclk cycles; ramp must be unchanged afterwards.
      pattern_en = 1'b0;
      sample = 8'hFF;
      frame(7, 5, 1'b0, 8'h00);
      pattern_en = 1'b1;
      frame(16, 5, 1'b0, 8'h00);

      // Sample changed mid-frame.
      pattern_en = 1'b0;
      sample = 8'h55;
      frame(16, 5, 1'b1, 8'hAA);
      frame(16, 5, 1'b0, 8'h00);

      // sclk toggling with cs_n high: no activity.
      for (int i = 0; i < 4; i++) begin
         sclk = 1'b0;
         tick(5);
         chk("csh_oe", sdata_oe, 1'b0);
         chk("csh_busy", busy, 1'b0);
         chk("csh_sdata", sdata, 1'b0);
         sclk = 1'b1;
         tick(5);
      end
      sample = 8'($urandom);
      frame(20, 5, 1'b0, 8'h00);

      // Randomized frames, including aborts.
      for (int i = 0; i < 8; i++) begin
         pattern_en = 1'($urandom_range(0, 1));
         sample = 8'($urandom);
         n = int'($urandom_range(1, 20));
         frame(n, int'($urandom_range(4, 6)), 1'b0, 8'h00);
      end

      n = 0;
      while (q.size() != 0 && n < 50) begin
         tick(1);
         n++;
      end
      chk("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
